// File: rtl/pilha_pkg.sv
// pilha_pkg: command codes and default sizes shared by the stack and the UC.
// Keep the encoding stable; the UC drives controle_pilha with these values.
package pilha_pkg;

    localparam int LARGURA_PADRAO      = 16;
    localparam int PROFUNDIDADE_PADRAO = 16;

    typedef enum logic [2:0] {
        CMD_NOP   = 3'd0,
        CMD_PUSH  = 3'd1,
        CMD_POP   = 3'd2,
        CMD_POP2  = 3'd3,
        CMD_REPL1 = 3'd4,
        CMD_REPL2 = 3'd5,
        CMD_CLEAR = 3'd6
    } cmd_e;

endpackage

// File: rtl/pilha_mem.sv
// pilha_mem: stack storage, one synchronous write port and two async reads.
// Not reset; only entries below the count are ever observed.
module pilha_mem #(
    parameter int LARGURA      = 16,
    parameter int PROFUNDIDADE = 16,
    localparam int AW          = $clog2(PROFUNDIDADE)
) (
    input  logic               clock,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  logic [LARGURA-1:0] i_wdata,
    input  logic [AW-1:0]      i_raddr_a,
    input  logic [AW-1:0]      i_raddr_b,
    output logic [LARGURA-1:0] o_rdata_a,
    output logic [LARGURA-1:0] o_rdata_b
);

    logic [LARGURA-1:0] r_mem [PROFUNDIDADE];

    // single write port
    always_ff @(posedge clock) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/pilha_lifo.sv
// pilha_lifo: hardware operand stack with count, sticky error flags and ack.
// Rejected commands leave memory and count untouched; only the flags move.
module pilha_lifo
    import pilha_pkg::*;
#(
    parameter int LARGURA      = LARGURA_PADRAO,
    parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO,
    localparam int AW          = $clog2(PROFUNDIDADE),
    localparam int CW          = $clog2(PROFUNDIDADE) + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pilha_wren,
    input  logic [2:0]         controle_pilha,
    input  logic [LARGURA-1:0] data_pilha,
    output logic [LARGURA-1:0] topo,
    output logic [LARGURA-1:0] segundo,
    output logic [CW-1:0]      contagem,
    output logic               vazia,
    output logic               cheia,
    output logic               ack,
    output logic               overflow,
    output logic               underflow
);

    logic [CW-1:0]      r_count;
    logic               r_ack;
    logic               r_ovf;
    logic               r_unf;

    logic [CW-1:0]      w_cnt_nxt;
    logic               w_we;
    logic [AW-1:0]      w_waddr;
    logic               w_ovf_set;
    logic               w_unf_set;
    logic               w_clr;
    logic               w_vazia;
    logic               w_cheia;
    logic               w_ge2;
    logic [AW-1:0]      w_ra_topo;
    logic [AW-1:0]      w_ra_seg;
    logic [LARGURA-1:0] w_rd_topo;
    logic [LARGURA-1:0] w_rd_seg;

    assign w_vazia   = (r_count == '0);
    assign w_cheia   = (r_count == CW'(PROFUNDIDADE));
    assign w_ge2     = (r_count >= CW'(2));
    assign w_ra_topo = r_count[AW-1:0] - AW'(1);
    assign w_ra_seg  = r_count[AW-1:0] - AW'(2);

    // command decode: next count, write request and error requests
    always_comb begin
        w_cnt_nxt = r_count;
        w_we      = 1'b0;
        w_waddr   = r_count[AW-1:0];
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        w_clr     = 1'b0;
        if (pilha_wren) begin
            case (controle_pilha)
                CMD_PUSH: begin
                    if (w_cheia) w_ovf_set = 1'b1;
                    else begin
                        w_we      = 1'b1;
                        w_cnt_nxt = r_count + CW'(1);
                    end
                end
                CMD_POP: begin
                    if (w_vazia) w_unf_set = 1'b1;
                    else w_cnt_nxt = r_count - CW'(1);
                end
                CMD_POP2: begin
                    if (!w_ge2) w_unf_set = 1'b1;
                    else w_cnt_nxt = r_count - CW'(2);
                end
                CMD_REPL1: begin
                    if (w_vazia) w_unf_set = 1'b1;
                    else begin
                        w_we    = 1'b1;
                        w_waddr = w_ra_topo;
                    end
                end
                CMD_REPL2: begin
                    if (!w_ge2) w_unf_set = 1'b1;
                    else begin
                        w_we      = 1'b1;
                        w_waddr   = w_ra_seg;
                        w_cnt_nxt = r_count - CW'(1);
                    end
                end
                CMD_CLEAR: begin
                    w_clr     = 1'b1;
                    w_cnt_nxt = '0;
                end
                default: ;
            endcase
        end
    end

    // reset must also block the write so a coincident strobe is discarded
    pilha_mem #(
        .LARGURA     (LARGURA),
        .PROFUNDIDADE(PROFUNDIDADE)
    ) u_mem (
        .clock    (clock),
        .i_we     (w_we & ~reset),
        .i_waddr  (w_waddr),
        .i_wdata  (data_pilha),
        .i_raddr_a(w_ra_topo),
        .i_raddr_b(w_ra_seg),
        .o_rdata_a(w_rd_topo),
        .o_rdata_b(w_rd_seg)
    );

    // count, ack and sticky flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_ack   <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_count <= w_cnt_nxt;
            r_ack   <= pilha_wren;
            if (w_clr) begin
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end else begin
                r_ovf <= r_ovf | w_ovf_set;
                r_unf <= r_unf | w_unf_set;
            end
        end
    end

    assign topo      = w_vazia ? '0 : w_rd_topo;
    assign segundo   = w_ge2 ? w_rd_seg : '0;
    assign contagem  = r_count;
    assign vazia     = w_vazia;
    assign cheia     = w_cheia;
    assign ack       = r_ack;
    assign overflow  = r_ovf;
    assign underflow = r_unf;

endmodule

// File: doc/pilha_lifo.md
PILHA_LIFO -- requirements
Module: pilha_lifo

Interface
REQ-001 Parameter LARGURA, default 16, data word width in bits.
REQ-002 Parameter PROFUNDIDADE, default 16, number of stack entries (power of two, 2..32).
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pilha_wren  input  1  command strobe from UC; one command accepted per cycle it is high.
REQ-006 controle_pilha  input  3  command code: NOP, PUSH, POP, POP2, REPL1, REPL2, CLEAR.
REQ-007 data_pilha  input  LARGURA  write data for PUSH/REPL1/REPL2.
REQ-008 topo  output  LARGURA  top-of-stack word; 0 when empty.
REQ-009 segundo  output  LARGURA  word below top; 0 when count<2.
REQ-010 contagem  output  clog2(PROFUNDIDADE)+1  number of valid entries, 0..PROFUNDIDADE.
REQ-011 vazia / cheia  output  1 each  count==0 / count==PROFUNDIDADE.
REQ-012 ack  output  1  registered; high exactly one cycle after each accepted strobe.
REQ-013 overflow / underflow  output  1 each  sticky error flags.

Function
REQ-014 Command executes on the rising edge where pilha_wren=1; topo/segundo/contagem reflect it immediately after that edge.
REQ-015 ack SHALL be 1 in the cycle following every strobe, including rejected and NOP commands; back-to-back strobes yield continuous ack.
REQ-016 PUSH: mem[count]<=data, count+1; when cheia, no state change, overflow<=1.
REQ-017 POP: count-1; when vazia, no change, underflow<=1.
REQ-018 POP2: count-2; when count<2, no change, underflow<=1.
REQ-019 REPL1 (unary op, e.g. NOT): mem[count-1]<=data, count unchanged; when vazia, no change, underflow<=1.
REQ-020 REPL2 (binary ALU result): mem[count-2]<=data, count-1; when count<2, no change, underflow<=1.
REQ-021 CLEAR: count<=0, overflow<=0, underflow<=0; memory contents untouched.
REQ-022 NOP and undefined codes: no state change, ack still generated.
REQ-023 topo/segundo SHALL be combinational reads of the memory at count-1/count-2, gated to 0 when invalid.
REQ-024 Error flags remain set until CLEAR or reset; a rejected command never modifies memory or count.
REQ-025 No wrap-around: count saturates at 0 and PROFUNDIDADE by rejection, never by modulo.
REQ-026 pilha_wren=0: all state holds.

Reset
REQ-027 reset asserted SHALL immediately force count=0, ack=0, overflow=0, underflow=0, so topo=segundo=0, vazia=1, cheia=0.
REQ-028 Memory array is not reset; contents are don't-care after reset.
REQ-029 reset asserted in the same cycle as a strobe SHALL win; the command is discarded and no ack follows.
REQ-030 First command is accepted on the first rising edge after reset deasserts.

Structure
REQ-031 Shared package pilha_pkg SHALL hold the command codes (NOP=0, PUSH=1, POP=2, POP2=3, REPL1=4, REPL2=5, CLEAR=6) and default LARGURA/PROFUNDIDADE; the UC imports the same package.
REQ-032 One sub-module, pilha_mem: PROFUNDIDADE x LARGURA register file, one synchronous write port, two asynchronous read ports.
REQ-033 pilha_lifo holds count, flags, ack and command decode.

Verification
REQ-034 Reset, PUSH 0x0005, PUSH 0x0003 -> contagem=2, topo=0x0003, segundo=0x0005, ack high one cycle after each strobe.
REQ-035 From that state, REPL2 data=0x0008 -> contagem=1, topo=0x0008, segundo=0; then REPL1 data=0xFFF7 -> topo=0xFFF7, contagem=1.
REQ-036 16 PUSHes of 0x0000..0x000F -> cheia=1, topo=0x000F; 17th PUSH 0x00AA -> overflow=1, topo=0x000F, contagem=16, ack=1.
REQ-037 From empty, POP then POP2 with one entry -> underflow=1, contagem unchanged (0, then 1); CLEAR -> underflow=0, contagem=0.
REQ-038 Assert reset mid-sequence coincident with PUSH 0x1234 -> contagem=0, no ack next cycle; PUSH after release -> topo=0x1234.
